// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lends one UART transmitter to two byte-stream requesters.
// A grant holds the UART for one packet. Release happens on the last byte, a dropped request or an idle timeout.
module uart_tx_arbiter #(
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       a_req,
   input  logic       b_req,
   output logic       a_gnt,
   output logic       b_gnt,
   input  logic       a_send,
   input  logic       b_send,
   input  logic [7:0] a_data,
   input  logic [7:0] b_data,
   input  logic       a_last,
   input  logic       b_last,
   output logic       a_ready,
   output logic       b_ready,
   output logic       a_finish,
   output logic       b_finish,
   input  logic       tx_ready,
   output logic       tx_send,
   output logic [7:0] tx_data,
   input  logic       tx_finish,
   output logic [1:0] owner,
   output logic       timeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_SEND  = 2'd2,
      ST_WAIT  = 2'd3
   } state_e;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_A    = 2'b01;
   localparam logic [1:0] OWN_B    = 2'b10;

   state_e      state_q;
   logic [1:0]  owner_q;
   logic        last_served_q;   // 1'b1 means B was served most recently
   logic        last_flag_q;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic [7:0]  tx_data_q;
   logic        tx_send_q;
   logic        a_finish_q;
   logic        b_finish_q;
   logic        timeout_q;
   logic [1:0]  grant_d;

   logic        own_req_s;
   logic        own_send_s;
   logic        own_last_s;
   logic [7:0]  own_data_s;
   logic        accept_s;
   logic        in_grant_s;

   // Steer the current owner's handshake inputs onto a common set of signals.
   always_comb begin
      own_req_s  = 1'b0;
      own_send_s = 1'b0;
      own_last_s = 1'b0;
      own_data_s = 8'h00;
      case (owner_q)
         OWN_A: begin
            own_req_s  = a_req;
            own_send_s = a_send;
            own_last_s = a_last;
            own_data_s = a_data;
         end
         OWN_B: begin
            own_req_s  = b_req;
            own_send_s = b_send;
            own_last_s = b_last;
            own_data_s = b_data;
         end
         default: begin
            own_req_s  = 1'b0;
            own_send_s = 1'b0;
            own_last_s = 1'b0;
            own_data_s = 8'h00;
         end
      endcase
   end

   // Round-robin choice used when leaving IDLE; ties go to whoever was not served last.
   always_comb begin
      if (a_req && b_req) begin
         grant_d = last_served_q ? OWN_A : OWN_B;
      end else if (a_req) begin
         grant_d = OWN_A;
      end else if (b_req) begin
         grant_d = OWN_B;
      end else begin
         grant_d = OWN_NONE;
      end
   end

   assign in_grant_s = (state_q == ST_GRANT);
   assign accept_s   = in_grant_s && own_send_s && tx_ready;

   // Idle counter runs only while the owner could send but does not; it saturates.
   always_comb begin
      if (in_grant_s && tx_ready && !accept_s && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign a_ready  = in_grant_s && (owner_q == OWN_A) && tx_ready;
   assign b_ready  = in_grant_s && (owner_q == OWN_B) && tx_ready;
   assign a_gnt    = owner_q[0];
   assign b_gnt    = owner_q[1];
   assign owner    = owner_q;
   assign tx_send  = tx_send_q;
   assign tx_data  = tx_data_q;
   assign a_finish = a_finish_q;
   assign b_finish = b_finish_q;
   assign timeout  = timeout_q;

   // Arbitration and byte-forwarding state machine with registered outputs.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q       <= ST_IDLE;
         owner_q       <= OWN_NONE;
         last_served_q <= 1'b1;
         last_flag_q   <= 1'b0;
         cnt_q         <= 16'd0;
         tx_data_q     <= 8'h00;
         tx_send_q     <= 1'b0;
         a_finish_q    <= 1'b0;
         b_finish_q    <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         tx_send_q  <= 1'b0;
         a_finish_q <= 1'b0;
         b_finish_q <= 1'b0;
         timeout_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_d != OWN_NONE) begin
                  owner_q <= grant_d;
                  cnt_q   <= 16'd0;
                  state_q <= ST_GRANT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (accept_s) begin
                  tx_data_q   <= own_data_s;
                  last_flag_q <= own_last_s;
                  tx_send_q   <= 1'b1;
                  state_q     <= ST_SEND;
               end else if (!own_req_s) begin
                  state_q       <= ST_IDLE;
                  owner_q       <= OWN_NONE;
                  last_served_q <= (owner_q == OWN_B);
                  cnt_q         <= 16'd0;
               end else if (cnt_q >= TIMEOUT) begin
                  state_q       <= ST_IDLE;
                  owner_q       <= OWN_NONE;
                  last_served_q <= (owner_q == OWN_B);
                  cnt_q         <= 16'd0;
                  timeout_q     <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_SEND: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (tx_finish) begin
                  a_finish_q <= (owner_q == OWN_A);
                  b_finish_q <= (owner_q == OWN_B);
                  if (last_flag_q || !own_req_s) begin
                     state_q       <= ST_IDLE;
                     owner_q       <= OWN_NONE;
                     last_served_q <= (owner_q == OWN_B);
                  end else begin
                     state_q <= ST_GRANT;
                  end
                  cnt_q <= 16'd0;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               owner_q <= OWN_NONE;
               cnt_q   <= 16'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the UART is modelled inline with a 10-cycle byte time.
module tb_uart_tx_arbiter;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       a_req, b_req, a_send, b_send, a_last, b_last;
   logic [7:0] a_data, b_data;
   logic       a_gnt, b_gnt, a_ready, b_ready, a_finish, b_finish;
   logic       tx_ready, tx_send, tx_finish, timeout;
   logic [7:0] tx_data;
   logic [1:0] owner;
   int         checks = 0;
   int         failures = 0;

   uart_tx_arbiter #(.TIMEOUT(16'd20)) dut (
      .Clock(Clock), .Reset(Reset),
      .a_req(a_req), .b_req(b_req), .a_gnt(a_gnt), .b_gnt(b_gnt),
      .a_send(a_send), .b_send(b_send), .a_data(a_data), .b_data(b_data),
      .a_last(a_last), .b_last(b_last), .a_ready(a_ready), .b_ready(b_ready),
      .a_finish(a_finish), .b_finish(b_finish), .tx_ready(tx_ready),
      .tx_send(tx_send), .tx_data(tx_data), .tx_finish(tx_finish),
      .owner(owner), .timeout(timeout)
   );

   always #5 Clock = ~Clock;

   wire [17:0] outs = {a_gnt, b_gnt, a_ready, b_ready, a_finish, b_finish,
                       tx_send, timeout, owner, tx_data};

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      a_req = 1'b0; b_req = 1'b0; a_send = 1'b0; b_send = 1'b0;
      a_last = 1'b0; b_last = 1'b0; a_data = 8'h00; b_data = 8'h00;
      tx_ready = 1'b1; tx_finish = 1'b0;
      repeat (2) tick();
      Reset = 1'b1;
   endtask

   // Drives one byte through the owner's handshake and the UART; returns what was observed.
   task automatic do_byte(input logic is_b, input logic [7:0] d, input logic last, input logic drop,
                          output logic rdy, output logic snd, output logic [7:0] dat,
                          output logic stable, output logic fin, output logic other_fin,
                          output logic [1:0] own_after);
      int n;
      n = 0;
      while (((is_b ? b_ready : a_ready) !== 1'b1) && n < 40) begin
         tick();
         n++;
      end
      rdy = (n < 40);
      if (is_b) begin b_send = 1'b1; b_data = d; b_last = last; end
      else      begin a_send = 1'b1; a_data = d; a_last = last; end
      tick();
      a_send = 1'b0; b_send = 1'b0; a_last = 1'b0; b_last = 1'b0;
      snd = tx_send;
      dat = tx_data;
      stable = (a_ready === 1'b0) && (b_ready === 1'b0);
      if (drop) begin
         if (is_b) b_req = 1'b0; else a_req = 1'b0;
      end
      tx_ready = 1'b0;
      repeat (9) begin
         tick();
         if (tx_data !== dat || tx_send !== 1'b0) stable = 1'b0;
      end
      tx_finish = 1'b1;
      tick();
      tx_finish = 1'b0;
      tx_ready = 1'b1;
      fin = is_b ? b_finish : a_finish;
      other_fin = is_b ? a_finish : b_finish;
      own_after = owner;
   endtask

   task automatic test_reset();
      do_reset();
      Reset = 1'b0;
      tick();
      checks++;
      if (outs !== 18'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want 0", outs);
      end
      Reset = 1'b1;
      tick();
      checks++;
      if (outs !== 18'd0) begin
         failures++;
         $display("FAIL idle_after_reset: got %h want 0", outs);
      end
   endtask

   task automatic test_single();
      logic r, s, st, f, of;
      logic [7:0] dt;
      logic [1:0] ow;
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
      do_reset();
      a_req = 1'b1;
      tick();
      checks++;
      if ({a_gnt, b_gnt, owner, a_ready, b_ready} !== 6'b10_01_10) begin
         failures++;
         $display("FAIL single_grant: got %b want 100110", {a_gnt, b_gnt, owner, a_ready, b_ready});
      end
      for (int i = 0; i < 3; i++) begin
         do_byte(1'b0, exp_d[i], (i == 2), 1'b0, r, s, dt, st, f, of, ow);
         checks++;
         if ({r, s, st, f, of} !== 5'b11110 || dt !== exp_d[i]) begin
            failures++;
            $display("FAIL single_byte%0d: flags %b data %h want 11110 data %h", i, {r, s, st, f, of}, dt, exp_d[i]);
         end
         checks++;
         if (ow !== ((i == 2) ? 2'b00 : 2'b01) || a_gnt !== (i != 2)) begin
            failures++;
            $display("FAIL single_owner%0d: owner %b gnt %b", i, ow, a_gnt);
         end
      end
      a_req = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_back_to_back();
      logic r, s, st, f, of;
      logic [7:0] dt;
      logic [1:0] ow;
      do_reset();
      a_req = 1'b1; b_req = 1'b1;
      tick();
      checks++;
      if (owner !== 2'b01 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL tie_first: owner %b b_ready %b want 01 0", owner, b_ready);
      end
      do_byte(1'b0, 8'h10, 1'b0, 1'b0, r, s, dt, st, f, of, ow);
      do_byte(1'b0, 8'h11, 1'b1, 1'b0, r, s, dt, st, f, of, ow);
      checks++;
      if (ow !== 2'b00 || dt !== 8'h11 || f !== 1'b1) begin
         failures++;
         $display("FAIL a_release: owner %b data %h fin %b want 00 11 1", ow, dt, f);
      end
      tick();
      checks++;
      if (owner !== 2'b10 || b_gnt !== 1'b1) begin
         failures++;
         $display("FAIL tie_second: owner %b want 10", owner);
      end
      do_byte(1'b1, 8'h20, 1'b1, 1'b0, r, s, dt, st, f, of, ow);
      checks++;
      if (f !== 1'b1 || of !== 1'b0 || dt !== 8'h20 || ow !== 2'b00) begin
         failures++;
         $display("FAIL b_packet: fin %b other %b data %h owner %b", f, of, dt, ow);
      end
      tick();
      checks++;
      if (owner !== 2'b01) begin
         failures++;
         $display("FAIL tie_third: owner %b want 01", owner);
      end
      a_req = 1'b0; b_req = 1'b0;
      tick();
      checks++;
      if (owner !== 2'b00) begin
         failures++;
         $display("FAIL req_drop_release: owner %b want 00", owner);
      end
   endtask

   task automatic test_drop_mid_packet();
      logic r, s, st, f, of;
      logic [7:0] dt;
      logic [1:0] ow;
      do_reset();
      a_req = 1'b1;
      tick();
      b_req = 1'b1;
      do_byte(1'b0, 8'h55, 1'b0, 1'b1, r, s, dt, st, f, of, ow);
      checks++;
      if ({s, st, f} !== 3'b111 || dt !== 8'h55 || ow !== 2'b00) begin
         failures++;
         $display("FAIL drop_complete: flags %b data %h owner %b want 111 55 00", {s, st, f}, dt, ow);
      end
      tick();
      checks++;
      if (owner !== 2'b10 || b_gnt !== 1'b1) begin
         failures++;
         $display("FAIL drop_b_grant: owner %b want 10", owner);
      end
      do_byte(1'b1, 8'h66, 1'b1, 1'b0, r, s, dt, st, f, of, ow);
      b_req = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_illegal_sends();
      logic r, s, st, f, of;
      logic [7:0] dt;
      logic [1:0] ow;
      do_reset();
      a_req = 1'b1;
      tick();
      do_byte(1'b0, 8'h5A, 1'b0, 1'b0, r, s, dt, st, f, of, ow);
      b_send = 1'b1; b_data = 8'hFF;
      tick();
      b_send = 1'b0;
      checks++;
      if (tx_send !== 1'b0 || tx_data !== 8'h5A) begin
         failures++;
         $display("FAIL nonowner_send: tx_send %b data %h want 0 5a", tx_send, tx_data);
      end
      tick();
      checks++;
      if (b_finish !== 1'b0 || tx_send !== 1'b0 || owner !== 2'b01) begin
         failures++;
         $display("FAIL nonowner_effect: b_finish %b tx_send %b owner %b", b_finish, tx_send, owner);
      end
      tx_ready = 1'b0;
      a_send = 1'b1; a_data = 8'h77;
      #1;
      checks++;
      if (a_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_follows_tx: a_ready %b want 0", a_ready);
      end
      tick();
      a_send = 1'b0;
      tick();
      checks++;
      if (tx_send !== 1'b0 || tx_data !== 8'h5A) begin
         failures++;
         $display("FAIL notready_send: tx_send %b data %h want 0 5a", tx_send, tx_data);
      end
      tx_ready = 1'b1;
      tx_finish = 1'b1;
      tick();
      tx_finish = 1'b0;
      checks++;
      if (a_finish !== 1'b0 || a_ready !== 1'b1) begin
         failures++;
         $display("FAIL stray_finish: a_finish %b a_ready %b want 0 1", a_finish, a_ready);
      end
      a_req = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_timeout();
      logic held;
      do_reset();
      a_req = 1'b1; b_req = 1'b1;
      tick();
      held = (a_gnt === 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (a_gnt !== 1'b1 || timeout !== 1'b0) held = 1'b0;
      end
      checks++;
      if (held !== 1'b1) begin
         failures++;
         $display("FAIL timeout_early: grant not held for 20 idle cycles");
      end
      tick();
      checks++;
      if (timeout !== 1'b1 || a_gnt !== 1'b0 || owner !== 2'b00) begin
         failures++;
         $display("FAIL timeout_pulse: timeout %b gnt %b owner %b want 1 0 00", timeout, a_gnt, owner);
      end
      tick();
      checks++;
      if (timeout !== 1'b0 || owner !== 2'b10) begin
         failures++;
         $display("FAIL timeout_rr: timeout %b owner %b want 0 10", timeout, owner);
      end
      a_req = 1'b0; b_req = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_async_reset();
      logic r, s, st, f, of;
      logic [7:0] dt;
      logic [1:0] ow;
      do_reset();
      a_req = 1'b1;
      tick();
      a_send = 1'b1; a_data = 8'h99; a_last = 1'b1;
      tick();
      a_send = 1'b0; a_last = 1'b0;
      checks++;
      if (tx_send !== 1'b1 || tx_data !== 8'h99) begin
         failures++;
         $display("FAIL pre_reset_send: tx_send %b data %h want 1 99", tx_send, tx_data);
      end
      #2;
      Reset = 1'b0;
      #1;
      checks++;
      if (outs !== 18'd0) begin
         failures++;
         $display("FAIL async_reset: got %h want 0", outs);
      end
      tick();
      Reset = 1'b1;
      tick();
      checks++;
      if (owner !== 2'b01) begin
         failures++;
         $display("FAIL post_reset_grant: owner %b want 01", owner);
      end
      do_byte(1'b0, 8'hC3, 1'b1, 1'b0, r, s, dt, st, f, of, ow);
      checks++;
      if ({r, s, st, f} !== 4'b1111 || dt !== 8'hC3 || ow !== 2'b00) begin
         failures++;
         $display("FAIL post_reset_byte: flags %b data %h owner %b", {r, s, st, f}, dt, ow);
      end
      a_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_drop_mid_packet();
      test_illegal_sends();
      test_timeout();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter (`UART_WriteD`) between two byte-stream requesters, A and B. A typical pairing is the CPU's opaque write buffer and a debug/status dumper. The block grants the transmitter to one requester per packet using round-robin arbitration, forwards bytes through the `ready/send/finish` handshake, and releases the lock at end of packet, when the request drops, or on an idle timeout. It sits between the requesters and the UART's `ready/send/finish/data` port.

## Interface
- `TIMEOUT`, default 16'd50000: idle cycles a granted owner may stay silent, with `tx_ready` high, before the lock is forcibly released.
- `Clock` in 1: sole clock.
- `Reset` in 1: asynchronous, active-low reset.
- `a_req`, `b_req` in 1 each: level request, held for the whole packet.
- `a_gnt`, `b_gnt` out 1 each: registered grant (lock ownership).
- `a_send`, `b_send` in 1 each: one-cycle byte strobe, honoured only when the matching `*_ready` is high.
- `a_data`, `b_data` in 8 each: byte, sampled with `*_send`.
- `a_last`, `b_last` in 1 each: sampled with `*_send`; marks this byte as the final byte of the packet.
- `a_ready`, `b_ready` out 1 each: the owner may strobe send this cycle.
- `a_finish`, `b_finish` out 1 each: one-cycle pulse when that requester's byte has left the line.
- `tx_ready` in 1: from the UART, idle.
- `tx_send` out 1: to the UART, one-cycle start pulse.
- `tx_data` out 8: to the UART.
- `tx_finish` in 1: from the UART, byte-done pulse.
- `owner` out 2: 00 none, 01 A, 10 B.
- `timeout` out 1: one-cycle pulse on forced release.

## Operation
- **States:** IDLE, GRANT, SEND, WAIT. Internal registers: `owner`, `last_served`, byte-is-last flag, timeout counter (16 bit).
- **IDLE:**
  - With no request, remain in IDLE.
  - With one request, grant it.
  - With both requests, grant the requester that is not `last_served`.
  - Next state is GRANT, with `*_gnt` and `owner` set.
- **GRANT:**
  - `*_ready` for the owner = `tx_ready`, combinational from state. The other requester's `*_ready` is 0.
  - If the owner's send is strobed with ready high: capture data into `tx_data`, capture last into the last flag, go to SEND.
  - Else if the owner's req is low: release.
  - Else if the counter reaches `TIMEOUT`: release and pulse `timeout`.
- **SEND:** `tx_send` = 1 for this single cycle, then go to WAIT.
- **WAIT:**
  - `tx_data` is held stable throughout.
  - On `tx_finish`, pulse the owner's `*_finish` on the next cycle.
  - Then, if the last flag is set or the owner's req is low, release. Otherwise return to GRANT.
- **Release:**
  - Go to IDLE; clear `gnt` and `owner`.
  - Set `last_served` = the releasing owner.
  - Clear the counter.
- **Timeout counter:**
  - Increments only in GRANT while `tx_ready` is high and there is no send.
  - Clears on entering GRANT.
  - Saturates; it does not wrap.
- **Ignored inputs:**
  - Send from a non-owner, or send while ready is low: ignored and dropped; no state change.
  - `tx_finish` outside WAIT: ignored.
- **Request dropped mid-byte (SEND/WAIT):** the byte completes and finish still pulses; release follows.

## Timing
- **Reset values:**
  - State IDLE; all `gnt`, `ready`, `finish` and `tx_send` = 0.
  - `tx_data` = 0, `owner` = 00, `timeout` = 0.
  - `last_served` = B, so A wins the first tie.
- **Reset mid-byte:** all outputs return to their reset values immediately, asynchronously. `tx_send` is never left high.
- **Grant latency:** req high in IDLE at cycle t → `gnt`/`owner` high at t+1; `ready` is visible from t+1 if `tx_ready` is high.
- **Byte path:** send accepted at t → `tx_send` high exactly at t+1 with `tx_data` valid → `ready` low from t+1 until the return to GRANT.
- **Finish path:** `tx_finish` at cycle f → `*_finish` pulse at f+1; state is GRANT or IDLE at f+1.
- **Next byte:** an owner may issue its next send no earlier than f+1.
- **Re-arbitration:** after release at cycle r (state IDLE at r), a new grant appears at r+1 at the earliest.
- **Back-to-back packets:** both requesters held high strictly alternate A, B, A, ...
- **Forced release:** `timeout` pulses in the cycle the state becomes IDLE.

## Test plan
- **Single requester:** reset, then A req with a 3-byte packet 0x41, 0x42, 0x43 (last on 0x43), UART model with 10-cycle byte time → `tx_data` sequence 41, 42, 43; three `a_finish` pulses; `a_gnt` low at f+1 of the third finish; `owner` = 00.
- **Simultaneous requests:** A and B req in the same cycle after reset → A granted first; B granted after A's last byte; next tie goes to A again only after B has been served.
- **Request dropped mid-packet:** A drops req during WAIT of byte 0x55 → 0x55 completes, `a_finish` pulses, release, and B (waiting) is granted the next cycle.
- **Illegal sends:** B strobes send with 0xFF while A owns → no `tx_send`, `tx_data` unchanged, no `b_finish`. A strobes send while `tx_ready` = 0 → ignored.
- **Idle timeout:** `TIMEOUT` = 20, A granted and never sends → after 20 idle cycles, `timeout` pulses, `a_gnt` drops, `last_served` = A, and B is granted if requesting.
- **Async reset mid-byte:** assert `Reset` low during SEND → `tx_send` low, all outputs at reset values immediately. After deassertion a fresh A packet transmits normally.
